output_credit_ctrl: RTL and testbench
=====================================

# output_credit_ctrl

Parametrised, credit-based output flow controller for one NoC router output port. It replaces the single-channel val/read/ret handshake with per-virtual-channel credit counters, round-robin arbitration among the local VC buffers, and a registered flit/valid output toward the neighbouring router. It sits between the router's per-VC output buffers (show-ahead FIFOs) and the link to the neighbour's input buffers.

## Interface
- NUM_VC, 2: number of virtual channels, ≥1
- DEPTH, 4: neighbour input-buffer depth per VC, which is also the initial credit count; ≥1
- DATA_W, 32: flit width
- CNT_W, $clog2(DEPTH+1): credit counter width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- empty  in  NUM_VC  per-VC local buffer empty flag
- flit_in  in  NUM_VC*DATA_W  head flit of each VC buffer; VC v occupies bits [v*DATA_W +: DATA_W]
- credit_in  in  NUM_VC  one-cycle credit-return pulse from the neighbour, one bit per VC
- read  out  NUM_VC  one-hot (or zero) pop strobe to the local VC buffers
- val  out  1  registered: flit_out is valid this cycle
- vc_out  out  max(1,$clog2(NUM_VC))  registered VC id of flit_out
- flit_out  out  DATA_W  registered flit to the link
- credit_err  out  1  sticky: credit overflow detected

## Operation
- State: credit[v] (CNT_W bits per VC), round-robin pointer ptr (VC index), and output registers val, vc_out, flit_out, credit_err.
- Eligibility (combinational): elig[v] = !empty[v] && credit[v] != 0.
- Arbitration: grant the first eligible VC found searching ptr, ptr+1, …, wrapping modulo NUM_VC. At most one grant per cycle; read = one-hot grant, or all zero if nothing is eligible.
- Pointer: on a grant to VC g, ptr ← (g+1) mod NUM_VC; with no grant, ptr holds.
- Output register: on a grant, val ← 1, vc_out ← g, flit_out ← flit_in slice g. With no grant, val ← 0 and vc_out/flit_out hold their previous values.
- Credit update per VC, same edge:
  - grant only: −1
  - credit_in only: +1
  - both: unchanged
  - neither: unchanged
- Overflow: if credit_in[v] arrives while credit[v] == DEPTH with no grant to v, the counter saturates at DEPTH and credit_err ← 1. credit_err stays set until rst.
- Underflow cannot occur, because a VC with zero credits is never granted.
- NUM_VC = 1 degenerates to a credit-gated single channel: vc_out is constantly 0 and ptr is constant.

## Timing
- Reset values (asynchronous, immediate on rst high):
  - credit[v] = DEPTH for every VC
  - ptr = 0
  - val = 0, vc_out = 0, flit_out = 0, credit_err = 0
- read is combinational from empty and the registered credit/ptr. It is asserted in the cycle the flit is selected, and the buffer pops at that cycle's clock edge.
- val/flit_out appear one cycle after read; latency from a non-empty eligible buffer to the link is 1 cycle.
- A credit returned in cycle t is usable for a grant in cycle t+1; there is no same-cycle bypass.
- Sustained throughput is 1 flit/cycle across VCs while credits allow. A single VC with DEPTH credits and no returns sends exactly DEPTH flits back-to-back, then stalls.
- Reset asserted mid-transfer: val drops asynchronously, credits reload to DEPTH, and any in-flight flit is dropped. The neighbour is reset in the same domain.

## Test plan
- Reset and idle: rst pulse with all empty=1. Required: val=0, read=0, credit_err=0 throughout; every credit reads 4.
- Single VC drain, NUM_VC=2, DEPTH=4: empty=2'b10, no credit_in.
  - Required: read[0] high for exactly 4 consecutive cycles, then 0.
  - val high for 4 cycles lagging read by 1, with vc_out=0 and flit_out matching each head flit.
- Round-robin fairness: both VCs non-empty with ample credits. Required: grants alternate 0,1,0,1…; vc_out follows the same sequence one cycle later.
- Credit return: exhaust VC0, then pulse credit_in[0] in cycle t. Required: read[0]=1 in t+1, val=1 in t+2.
- Simultaneous grant and credit return on VC0 at credit=1. Required: credit stays 1 and VC0 is granted again next cycle.
- Overflow: with credit[1]=4 and VC1 idle, pulse credit_in[1]. Required: credit_err=1 next cycle and stays set, credit[1] remains 4; a following rst clears credit_err.

Source files
------------

// File: rtl/output_credit_ctrl.sv
// Credit-based output flow controller for one NoC router output port.
// Round-robin arbitration over VC buffers gated by per-VC credits, with a registered link stage.
module output_credit_ctrl #(
    parameter  int NUM_VC = 2,
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_VC-1:0]        empty,
    input  logic [NUM_VC*DATA_W-1:0] flit_in,
    input  logic [NUM_VC-1:0]        credit_in,
    output logic [NUM_VC-1:0]        read,
    output logic                     val,
    output logic [VC_W-1:0]          vc_out,
    output logic [DATA_W-1:0]        flit_out,
    output logic                     credit_err
);

    logic [NUM_VC-1:0][CNT_W-1:0] credit_q, credit_d;
    logic [VC_W-1:0]              ptr_q, ptr_d;
    logic                         val_q, val_d;
    logic [VC_W-1:0]              vc_q, vc_d;
    logic [DATA_W-1:0]            flit_q, flit_d;
    logic                         err_q, err_d;

    logic [NUM_VC-1:0] elig;
    logic              gnt_vld;
    logic [VC_W-1:0]   gnt_idx;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            elig[v] = !empty[v] && (credit_q[v] != '0);
        end
    end

    // Search starts at ptr and wraps; the first eligible VC wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        read    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_VC) idx = idx - NUM_VC;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = VC_W'(idx);
            end
        end
        if (gnt_vld) read[gnt_idx] = 1'b1;
    end

    always_comb begin
        ptr_d  = ptr_q;
        val_d  = gnt_vld;
        vc_d   = vc_q;
        flit_d = flit_q;
        if (gnt_vld) begin
            ptr_d  = (int'(gnt_idx) == NUM_VC - 1) ? '0 : gnt_idx + 1'b1;
            vc_d   = gnt_idx;
            flit_d = flit_in[gnt_idx*DATA_W +: DATA_W];
        end
    end

    // A return arriving with the counter already full saturates and flags the error.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        for (int v = 0; v < NUM_VC; v++) begin
            case ({read[v], credit_in[v]})
                2'b10: credit_d[v] = credit_q[v] - 1'b1;
                2'b01: begin
                    if (credit_q[v] == CNT_W'(DEPTH)) err_d = 1'b1;
                    else                              credit_d[v] = credit_q[v] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) credit_q[v] <= CNT_W'(DEPTH);
            ptr_q  <= '0;
            val_q  <= 1'b0;
            vc_q   <= '0;
            flit_q <= '0;
            err_q  <= 1'b0;
        end else begin
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
            val_q    <= val_d;
            vc_q     <= vc_d;
            flit_q   <= flit_d;
            err_q    <= err_d;
        end
    end

    assign val        = val_q;
    assign vc_out     = vc_q;
    assign flit_out   = flit_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_output_credit_ctrl.sv
// Table-driven bench for output_credit_ctrl (NUM_VC=2, DEPTH=4) with a link-side scoreboard.
module tb_output_credit_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  empty;
    logic [63:0] flit_in;
    logic [1:0]  credit_in;
    logic [1:0]  read;
    logic        val;
    logic [0:0]  vc_out;
    logic [31:0] flit_out;
    logic        credit_err;

    output_credit_ctrl #(.NUM_VC(2), .DEPTH(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .empty(empty), .flit_in(flit_in),
        .credit_in(credit_in), .read(read), .val(val), .vc_out(vc_out),
        .flit_out(flit_out), .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] empty;
        logic [1:0] cin;
        logic [1:0] rd;
        logic       err;
    } vec_t;

    typedef struct {
        logic [0:0]  vc;
        logic [31:0] flit;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [1:0] e, input logic [1:0] c,
                                input logic [1:0] r, input logic er, input int reps);
        vec_t v;
        v.empty = e; v.cin = c; v.rd = r; v.err = er;
        for (int k = 0; k < reps; k++) tbl.push_back(v);
    endfunction

    // Drive one cycle, check read, and check the link stage one edge later.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        empty     = v.empty;
        credit_in = v.cin;
        n++;
        flit_in   = {32'hB000_0000 + 32'(n), 32'hA000_0000 + 32'(n)};
        #1;
        chk("read", 64'(read), 64'(v.rd));
        if (v.rd != 2'b00) begin
            e.vc   = v.rd[1];
            e.flit = v.rd[1] ? flit_in[63:32] : flit_in[31:0];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("val", 64'(val), 64'(v.rd != 2'b00));
        if (v.rd != 2'b00) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("vc_out", 64'(vc_out), 64'(e.vc));
                chk("flit_out", 64'(flit_out), 64'(e.flit));
            end
        end
        chk("credit_err", 64'(credit_err), 64'(v.err));
    endtask

    initial begin
        // idle
        add(2'b11, 2'b00, 2'b00, 1'b0, 2);
        // single VC drain: exactly DEPTH grants, then stall
        add(2'b10, 2'b00, 2'b01, 1'b0, 4);
        add(2'b10, 2'b00, 2'b00, 1'b0, 2);
        // credit return in t, grant in t+1
        add(2'b10, 2'b01, 2'b00, 1'b0, 1);
        add(2'b10, 2'b00, 2'b01, 1'b0, 1);
        add(2'b10, 2'b00, 2'b00, 1'b0, 1);
        // simultaneous grant and return at credit=1
        add(2'b10, 2'b01, 2'b00, 1'b0, 1);
        add(2'b10, 2'b01, 2'b01, 1'b0, 1);
        add(2'b10, 2'b00, 2'b01, 1'b0, 1);
        add(2'b10, 2'b00, 2'b00, 1'b0, 1);
        // refill VC0, then round robin starting at ptr=1
        add(2'b11, 2'b01, 2'b00, 1'b0, 4);
        for (int k = 0; k < 4; k++) begin
            add(2'b00, 2'b00, 2'b10, 1'b0, 1);
            add(2'b00, 2'b00, 2'b01, 1'b0, 1);
        end
        add(2'b00, 2'b00, 2'b00, 1'b0, 1);
        // refill VC1, then overflow and sticky error
        add(2'b11, 2'b10, 2'b00, 1'b0, 4);
        add(2'b11, 2'b10, 2'b00, 1'b1, 1);
        add(2'b11, 2'b00, 2'b00, 1'b1, 2);

        rst = 1'b1; empty = 2'b11; credit_in = 2'b00; flit_in = '0;
        #12;
        chk("rst_val", 64'(val), 64'(0));
        chk("rst_read", 64'(read), 64'(0));
        chk("rst_err", 64'(credit_err), 64'(0));
        chk("rst_vc_out", 64'(vc_out), 64'(0));
        chk("rst_credit0", 64'(dut.credit_q[0]), 64'(4));
        chk("rst_credit1", 64'(dut.credit_q[1]), 64'(4));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        chk("ovf_credit1", 64'(dut.credit_q[1]), 64'(4));
        chk("drain_credit0", 64'(dut.credit_q[0]), 64'(0));

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_err", 64'(credit_err), 64'(0));
        chk("rst2_credit1", 64'(dut.credit_q[1]), 64'(4));
        @(negedge clk);
        rst = 1'b0;

        // reset while a flit is on the link
        begin
            vec_t v;
            v.empty = 2'b00; v.cin = 2'b00; v.rd = 2'b01; v.err = 1'b0;
            step(v);
        end
        @(negedge clk);
        #1;
        chk("mid_read", 64'(read), 64'(2'b10));
        chk("mid_val_before", 64'(val), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_val", 64'(val), 64'(0));
        chk("mid_flit", 64'(flit_out), 64'(0));
        chk("mid_credit0", 64'(dut.credit_q[0]), 64'(4));
        @(negedge clk);
        rst = 1'b0;
        empty = 2'b11;
        sb.delete();
        begin
            vec_t v;
            v.empty = 2'b10; v.cin = 2'b00; v.rd = 2'b01; v.err = 1'b0;
            step(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
